// File: rtl/lsu_mem_master.sv
// ---------------------------------------------------------------------------
// lsu_mem_master
//
// Purpose:
//   Load/store access controller that sits between the core datapath and a
//   word-addressed unified memory. The memory offers a combinational word
//   read and a synchronous full-word write with no byte enables. This block
//   therefore does the following:
//   - accepts one byte/halfword/word access at a time over valid/ready;
//   - rejects misaligned, out-of-range and illegal-size accesses;
//   - extracts and extends load lanes;
//   - turns sub-word stores into read-modify-write.
//
// Ports:
//   clk           rising-edge clock
//   resetn        asynchronous active-low reset
//   req_valid     core presents a request
//   req_ready     high only while idle; request accepted on valid && ready
//   req_we        1 = store, 0 = load
//   req_size      00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned  loads: 1 = zero-extend, 0 = sign-extend
//   req_addr      byte address
//   req_wdata     right-aligned store data
//   resp_valid    one-cycle completion pulse
//   resp_rdata    extended load data (0 for stores/errors), held until next response
//   resp_error    error flag qualified by resp_valid, held until next response
//   mem_address   byte address to memory (memory uses bits [13:2])
//   mem_data_out  write data to memory
//   mem_data_in   combinational read data from memory
//   mem_we        memory write enable, high only in the WRITE state
// ---------------------------------------------------------------------------
module lsu_mem_master #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_out,
  input  logic [31:0] mem_data_in,
  output logic        mem_we
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MERGE,
    WRITE,
    RESP
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  // First byte address past the end of memory. The compare is done one bit
  // wider so that large MEM_WORDS values cannot overflow the limit.
  localparam logic [33:0] ADDR_LIMIT = 34'(MEM_WORDS) * 34'd4;

  state_t      r_state;
  state_t      w_next_state;

  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_we;
  logic        r_unsigned;
  logic [31:0] r_wdata;
  logic [31:0] r_merged;
  logic [31:0] r_rdata;
  logic        r_error;

  logic        w_accept;
  logic        w_req_error;
  logic [7:0]  w_byte_lane;
  logic [15:0] w_half_lane;
  logic [31:0] w_load_ext;
  logic [31:0] w_merge_word;

  assign w_accept = req_valid && (r_state == IDLE);

  // An access is rejected when any of the following holds:
  //   - its size is illegal;
  //   - it is not naturally aligned;
  //   - its byte address lies past the end of memory.
  // The address is never wrapped, so every out-of-range address is rejected
  // and none is aliased onto a valid word.
  always_comb begin
    w_req_error = 1'b0;
    if (req_size == SIZE_ILL) begin
      w_req_error = 1'b1;
    end
    if ((req_size == SIZE_HALF) && req_addr[0]) begin
      w_req_error = 1'b1;
    end
    if ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00)) begin
      w_req_error = 1'b1;
    end
    if ({2'b00, req_addr} >= ADDR_LIMIT) begin
      w_req_error = 1'b1;
    end
  end

  // Load lane extraction. A byte lane starts at addr[1:0]*8. A halfword lane
  // starts at addr[1]*16. The selected lane is then sign- or zero-extended.
  always_comb begin
    w_byte_lane = mem_data_in[{r_addr[1:0], 3'b000} +: 8];
    w_half_lane = mem_data_in[{r_addr[1], 4'b0000} +: 16];
    w_load_ext  = mem_data_in;
    case (r_size)
      SIZE_BYTE: w_load_ext = {{24{~r_unsigned & w_byte_lane[7]}}, w_byte_lane};
      SIZE_HALF: w_load_ext = {{16{~r_unsigned & w_half_lane[15]}}, w_half_lane};
      default:   w_load_ext = mem_data_in;
    endcase
  end

  // Read-modify-write merge. The addressed lane of the old word is replaced
  // with the right-aligned store data, and the other lanes are kept. A word
  // store simply takes the whole store word.
  always_comb begin
    w_merge_word = mem_data_in;
    case (r_size)
      SIZE_BYTE: w_merge_word[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
      SIZE_HALF: w_merge_word[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
      default:   w_merge_word = r_wdata;
    endcase
  end

  // State register. An asynchronous reset drops any in-flight access at
  // once. Because mem_we is decoded from the state, the reset also removes
  // the write enable immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and state-decoded outputs. The handshake, the response pulse
  // and the write enable all depend only on the current state, so they are
  // free of glitches from the request inputs.
  always_comb begin
    w_next_state = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    mem_we       = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_error) begin
            w_next_state = RESP;
          end else if (!req_we) begin
            w_next_state = LOAD;
          end else if (req_size == SIZE_WORD) begin
            w_next_state = WRITE;
          end else begin
            w_next_state = MERGE;
          end
        end
      end
      LOAD: begin
        w_next_state = RESP;
      end
      MERGE: begin
        w_next_state = WRITE;
      end
      WRITE: begin
        mem_we       = 1'b1;
        w_next_state = RESP;
      end
      RESP: begin
        resp_valid   = 1'b1;
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Request latch and datapath registers.
  // - The request fields are captured only on acceptance, so later input
  //   changes do not disturb an access in flight.
  // - The response data and error flag are loaded on the edge that enters
  //   RESP. They then hold until the next response.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr     <= '0;
      r_size     <= '0;
      r_we       <= 1'b0;
      r_unsigned <= 1'b0;
      r_wdata    <= '0;
      r_merged   <= '0;
      r_rdata    <= '0;
      r_error    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr     <= req_addr;
            r_size     <= req_size;
            r_we       <= req_we;
            r_unsigned <= req_unsigned;
            r_wdata    <= req_wdata;
            r_merged   <= req_wdata;
            if (w_req_error) begin
              r_rdata <= '0;
              r_error <= 1'b1;
            end
          end
        end
        LOAD: begin
          r_rdata <= r_we ? 32'h0 : w_load_ext;
          r_error <= 1'b0;
        end
        MERGE: begin
          r_merged <= w_merge_word;
        end
        WRITE: begin
          r_rdata <= '0;
          r_error <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_address  = r_addr;
  assign mem_data_out = r_merged;
  assign resp_rdata   = r_rdata;
  assign resp_error   = r_error;

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store access controller between the core's datapath and the word-addressed unified memory. The memory exposes a combinational word read and a synchronous full-word write.
- Accepts one byte, halfword or word load/store at a time over a valid/ready handshake.
- Performs alignment checks and byte-lane extraction with sign or zero extension.
- Implements sub-word stores as read-modify-write, because the memory has no byte enables.

Parameters:
MEM_WORDS, 1024, memory depth in 32-bit words; a byte address >= MEM_WORDS*4 is out of range.

Ports:
clk  input  1  clock; all state updates on rising edge
resetn  input  1  asynchronous, active-low reset
req_valid  input  1  core presents a request
req_ready  output  1  controller can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal
req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_error  output  1  qualified by resp_valid: misaligned, out-of-range or illegal size
mem_address  output  32  to memory address; memory indexes bits [13:2]
mem_data_out  output  32  to memory data_in
mem_data_in  input  32  from memory data_out (combinational read)
mem_we  output  1  to memory write enable

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset: state=IDLE. req_ready=1. resp_valid=0, resp_rdata=0, resp_error=0. mem_we=0. mem_address=0, mem_data_out=0. All latched request fields cleared.
- FSM states: IDLE, LOAD, MERGE, WRITE, RESP.
- req_ready=1 only in IDLE.
- A request is accepted on a rising edge with req_valid && req_ready. At acceptance, latch addr, size, we, unsigned and wdata. Input changes after acceptance are ignored.
- Error check at acceptance. Error if any of:
  - size=11;
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr >= MEM_WORDS*4.
  On error: go to RESP with resp_error=1; no memory write.
- IDLE transitions:
  - load -> LOAD;
  - store word -> WRITE, merged word = wdata;
  - store byte/half -> MERGE.
- LOAD: mem_address=latched addr. Capture mem_data_in. Select lane by addr[1:0]: byte lane = addr[1:0]*8; half lane = addr[1]*16. Extend per unsigned flag into resp_rdata. Then -> RESP.
- MERGE: mem_address=latched addr. Read old word and replace the addressed byte/half lane with wdata[7:0]/wdata[15:0]; other lanes unchanged. Then -> WRITE.
- WRITE: mem_we=1 for exactly this cycle. mem_address=latched addr, mem_data_out=merged word. Then -> RESP.
- RESP: resp_valid=1 for one cycle, then -> IDLE. resp_rdata and resp_error hold their values until the next request's RESP. resp_rdata=0 for stores and errors.
- Latency from accepting edge T, with resp_valid high in the cycle after:
  - error: T+1;
  - load: T+2;
  - word store: T+2, mem_we high in cycle T+1;
  - sub-word store: T+3, mem_we high in cycle T+2.
- Throughput: one outstanding request; the next request can be accepted in the IDLE cycle after RESP.
- mem_we is decoded from state only, so it is glitch-free and low in every state except WRITE.
- mem_address holds the last latched address outside active states.
- Reset mid-operation: state returns to IDLE immediately (asynchronously). mem_we deasserts at once. The pending request is dropped with no response; memory is unchanged unless the WRITE edge had already occurred.
- Address arithmetic: word index = addr[31:2]; no wrap. Out-of-range is an error, never aliased.

Test Plan:
- Preload mem word 4 (byte addr 0x10) = 0x8081F2F3. Issue:
  - load byte signed @0x11 -> resp_rdata=0xFFFFFFF2, resp_error=0, resp_valid at T+2;
  - load byte unsigned @0x11 -> 0x000000F2;
  - load half signed @0x12 -> 0xFFFF8081.
- Store half wdata=0x1234ABCD @0x12 -> mem_we high exactly one cycle (T+2). Word 4 becomes 0xABCDF2F3. resp_valid at T+3, resp_rdata=0.
- Store word 0xDEADBEEF @0x20 -> mem_we in cycle T+1, word 8 = 0xDEADBEEF, resp at T+2. A following word load @0x20 returns 0xDEADBEEF.
- Error cases: store word @0x13, load half @0x15, size=11 @0x0, load word @0x4000 -> each gives resp_error=1 at T+1, mem_we never asserted, resp_rdata=0.
- Back-to-back: hold req_valid continuously with 3 loads -> each accepted only while req_ready=1; 3 responses in order, no request lost or duplicated.
- Assert resetn=0 during MERGE of a byte store -> mem_we stays 0, memory unchanged, no resp_valid. After release, req_ready=1 and outputs are at reset values.
